// File: rtl/fv_bank_pkg.sv
// Shared definitions for the feature-value bank controller: FSM state codes,
// read-beat control struct and a width helper for parameter-derived ports.
package fv_bank_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WB     = 2'd2;
  localparam logic [1:0] ST_RD     = 2'd3;

  // Destination of a returned read beat
  localparam logic DST_SM = 1'b0;
  localparam logic DST_PE = 1'b1;

  typedef struct packed {
    logic valid;
    logic sos;
    logic eos;
    logic dst;
  } beat_ctl_t;

  // clog2 that never yields a zero-width bus
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fv_rd_pipe.sv
// One-stage read-return pipeline: carries beat control, PE tag and line address
// alongside the SRAM's one-cycle read latency.
module fv_rd_pipe
  import fv_bank_pkg::*;
#(
  parameter int TW = 2,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  beat_ctl_t     ctl_i,
  input  logic [TW-1:0] tag_i,
  input  logic [AW-1:0] addr_i,
  output beat_ctl_t     ctl_o,
  output logic [TW-1:0] tag_o,
  output logic [AW-1:0] addr_o
);

  beat_ctl_t     ctl_q;
  logic [TW-1:0] tag_q;
  logic [AW-1:0] addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_q  <= '0;
      tag_q  <= '0;
      addr_q <= '0;
    end else begin
      ctl_q  <= ctl_i;
      tag_q  <= tag_i;
      addr_q <= addr_i;
    end
  end

  assign ctl_o  = ctl_q;
  assign tag_o  = tag_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/fv_bank_cntl_gen.sv
// Controller for one FV SRAM bank: per-iteration bulk stream, node write-back
// and Edge PE node reads, with a shared one-cycle read-return pipeline.
module fv_bank_cntl_gen
  import fv_bank_pkg::*;
#(
  parameter int LINE_W         = 128,
  parameter int ELEM_W         = 16,
  parameter int LINES_PER_NODE = 8,
  parameter int NODES_PER_ITER = 8,
  parameter int MAX_ITER       = 8,
  parameter int NUM_PE         = 4,
  parameter int MAX_FV_NUM     = 64,
  localparam int EPL   = LINE_W / ELEM_W,
  localparam int DEPTH = MAX_ITER * NODES_PER_ITER * LINES_PER_NODE,
  localparam int AW    = width_of(DEPTH),
  localparam int NID_W = width_of(MAX_ITER * NODES_PER_ITER),
  localparam int ITW   = width_of(MAX_ITER),
  localparam int FVW   = width_of(MAX_FV_NUM) + 1,
  localparam int TW    = width_of(NUM_PE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stream_en,
  input  logic [ITW-1:0]    cur_replay_iter,
  input  logic [FVW-1:0]    fv_num,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [NID_W-1:0]  req_node_id,
  input  logic [TW-1:0]     req_pe_tag,
  input  logic [LINE_W-1:0] req_data,
  input  logic              req_wr_eos,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [AW-1:0]     sram_addr,
  output logic [LINE_W-1:0] sram_wdata,
  input  logic [LINE_W-1:0] sram_rdata,
  output logic              sm_valid,
  output logic              sm_sos,
  output logic              sm_eos,
  output logic [AW-1:0]     sm_addr,
  output logic [LINE_W-1:0] sm_data,
  output logic              pe_valid,
  output logic              pe_sos,
  output logic              pe_eos,
  output logic [TW-1:0]     pe_tag,
  output logic [LINE_W-1:0] pe_data,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int LCW = width_of(LINES_PER_NODE) + 1;
  localparam int NW  = width_of(NODES_PER_ITER);
  localparam int FSW = FVW + 1;

  logic [1:0]     state_q, state_d;
  logic [LCW-1:0] line_q, line_d;
  logic [LCW-1:0] nlines_q, nlines_d;
  logic [NW-1:0]  node_q, node_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [ITW-1:0] last_iter_q, last_iter_d;
  logic           first_done_q, first_done_d;
  logic [AW-1:0]  base_q, base_d;
  logic [TW-1:0]  tag_q, tag_d;
  logic           err_q, err_d;

  // Lines per node from the feature count, clamped to [1, LINES_PER_NODE]
  logic [FSW-1:0] nl_sum, nl_div;
  logic [LCW-1:0] nl_clamped;

  always_comb begin
    nl_sum = {1'b0, fv_num} + FSW'(EPL - 1);
    nl_div = nl_sum / FSW'(EPL);
    if (nl_div == '0)
      nl_clamped = LCW'(1);
    else if (nl_div > FSW'(LINES_PER_NODE))
      nl_clamped = LCW'(LINES_PER_NODE);
    else
      nl_clamped = LCW'(nl_div);
  end

  logic           trigger, stream_go, st_last;
  logic [LCW-1:0] st_pos_l, st_nl;
  logic [NW-1:0]  st_pos_n;
  logic [ITW-1:0] st_iter;
  logic [AW-1:0]  st_addr, node_base;
  logic           rd_en, wr_en, req_ready_c;
  logic [AW-1:0]  acc_addr;
  beat_ctl_t      iss_ctl;
  logic [TW-1:0]  iss_tag;

  // Streaming position: IDLE issues node 0 line 0 in the trigger cycle
  always_comb begin
    trigger   = stream_en && (!first_done_q || (cur_replay_iter != last_iter_q));
    stream_go = (state_q == ST_STREAM) || ((state_q == ST_IDLE) && trigger);
    st_pos_l  = (state_q == ST_STREAM) ? line_q   : '0;
    st_pos_n  = (state_q == ST_STREAM) ? node_q   : '0;
    st_nl     = (state_q == ST_STREAM) ? nlines_q : nl_clamped;
    st_iter   = (state_q == ST_STREAM) ? iter_q   : cur_replay_iter;
    st_last   = (st_pos_n == NW'(NODES_PER_ITER - 1)) && (st_pos_l == st_nl - LCW'(1));
    st_addr   = AW'(st_iter) * AW'(NODES_PER_ITER * LINES_PER_NODE)
              + AW'(st_pos_n) * AW'(LINES_PER_NODE) + AW'(st_pos_l);
    node_base = AW'(req_node_id) * AW'(LINES_PER_NODE);
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    nlines_d     = nlines_q;
    node_d       = node_q;
    iter_d       = iter_q;
    last_iter_d  = last_iter_q;
    first_done_d = first_done_q;
    base_d       = base_q;
    tag_d        = tag_q;
    err_d        = err_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    req_ready_c  = 1'b0;
    acc_addr     = '0;
    iss_ctl      = '0;
    iss_tag      = '0;

    case (state_q)
      ST_IDLE: begin
        // Requests are only served outside the update phase
        if (!stream_en) begin
          req_ready_c = 1'b1;
          if (req_valid) begin
            base_d   = node_base;
            line_d   = LCW'(1);
            acc_addr = node_base;
            if (req_wr) begin
              wr_en = 1'b1;
              if (!req_wr_eos) state_d = ST_WB;
            end else begin
              rd_en       = 1'b1;
              iss_ctl.sos = 1'b1;
              iss_ctl.eos = (nl_clamped == LCW'(1));
              iss_ctl.dst = DST_PE;
              iss_tag     = req_pe_tag;
              tag_d       = req_pe_tag;
              nlines_d    = nl_clamped;
              if (nl_clamped != LCW'(1)) state_d = ST_RD;
            end
          end
        end
      end
      ST_WB: begin
        req_ready_c = 1'b1;
        if (req_valid) begin
          if (line_q >= LCW'(LINES_PER_NODE)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wr_en    = 1'b1;
            acc_addr = base_q + AW'(line_q);
            line_d   = line_q + LCW'(1);
            if (req_wr_eos) state_d = ST_IDLE;
          end
        end
      end
      ST_RD: begin
        rd_en       = 1'b1;
        acc_addr    = base_q + AW'(line_q);
        iss_ctl.eos = (line_q == nlines_q - LCW'(1));
        iss_ctl.dst = DST_PE;
        iss_tag     = tag_q;
        line_d      = line_q + LCW'(1);
        if (iss_ctl.eos) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (stream_go) begin
      rd_en       = 1'b1;
      acc_addr    = st_addr;
      iss_ctl.sos = (st_pos_n == '0) && (st_pos_l == '0);
      iss_ctl.eos = st_last;
      iss_ctl.dst = DST_SM;
      iter_d      = st_iter;
      nlines_d    = st_nl;
      if (st_last) begin
        state_d      = ST_IDLE;
        first_done_d = 1'b1;
        last_iter_d  = st_iter;
        line_d       = '0;
        node_d       = '0;
      end else begin
        state_d = ST_STREAM;
        if (st_pos_l == st_nl - LCW'(1)) begin
          line_d = '0;
          node_d = st_pos_n + NW'(1);
        end else begin
          line_d = st_pos_l + LCW'(1);
          node_d = st_pos_n;
        end
      end
    end

    iss_ctl.valid = rd_en;
    // No SRAM access or handshake while reset is held
    if (reset) begin
      rd_en       = 1'b0;
      wr_en       = 1'b0;
      req_ready_c = 1'b0;
      acc_addr    = '0;
      iss_ctl     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      nlines_q     <= '0;
      node_q       <= '0;
      iter_q       <= '0;
      last_iter_q  <= '0;
      first_done_q <= 1'b0;
      base_q       <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      nlines_q     <= nlines_d;
      node_q       <= node_d;
      iter_q       <= iter_d;
      last_iter_q  <= last_iter_d;
      first_done_q <= first_done_d;
      base_q       <= base_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
    end
  end

  beat_ctl_t     ret_ctl;
  logic [TW-1:0] ret_tag;
  logic [AW-1:0] ret_addr;

  fv_rd_pipe #(.TW(TW), .AW(AW)) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .ctl_i  (iss_ctl),
    .tag_i  (iss_tag),
    .addr_i (acc_addr),
    .ctl_o  (ret_ctl),
    .tag_o  (ret_tag),
    .addr_o (ret_addr)
  );

  logic sm_hit, pe_hit;
  assign sm_hit = ret_ctl.valid && (ret_ctl.dst == DST_SM);
  assign pe_hit = ret_ctl.valid && (ret_ctl.dst == DST_PE);

  assign sm_valid = sm_hit;
  assign sm_sos   = sm_hit && ret_ctl.sos;
  assign sm_eos   = sm_hit && ret_ctl.eos;
  assign sm_addr  = sm_hit ? ret_addr : '0;
  assign sm_data  = sm_hit ? sram_rdata : '0;

  assign pe_valid = pe_hit;
  assign pe_sos   = pe_hit && ret_ctl.sos;
  assign pe_eos   = pe_hit && ret_ctl.eos;
  assign pe_tag   = pe_hit ? ret_tag : '0;
  assign pe_data  = pe_hit ? sram_rdata : '0;

  assign req_ready  = req_ready_c;
  assign sram_cen   = !(rd_en || wr_en);
  assign sram_wen   = !wr_en;
  assign sram_addr  = acc_addr;
  assign sram_wdata = wr_en ? req_data : '0;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fv_bank_cntl_gen.sv
// Randomised scoreboard bench for fv_bank_cntl_gen with a behavioural SRAM and
// a line-level reference memory.
module tb_fv_bank_cntl_gen;
  import fv_bank_pkg::*;

  localparam int LINE_W = 128;
  localparam int LPN    = 8;
  localparam int NPI    = 8;
  localparam int EPL    = 8;
  localparam int DEPTH  = 512;
  localparam int AW     = 9;
  localparam int NID_W  = 6;
  localparam int ITW    = 3;
  localparam int FVW    = 7;
  localparam int TW     = 2;
  localparam int SMW    = 2 + AW + LINE_W;
  localparam int PEW    = 2 + TW + LINE_W;
  localparam int WRW    = AW + LINE_W;

  logic              clk, reset, stream_en, req_valid, req_ready, req_wr, req_wr_eos;
  logic [ITW-1:0]    cur_replay_iter;
  logic [FVW-1:0]    fv_num;
  logic [NID_W-1:0]  req_node_id;
  logic [TW-1:0]     req_pe_tag, pe_tag;
  logic [LINE_W-1:0] req_data, sram_wdata, sram_rdata, sm_data, pe_data;
  logic              sram_cen, sram_wen, sm_valid, sm_sos, sm_eos;
  logic [AW-1:0]     sram_addr, sm_addr;
  logic              pe_valid, pe_sos, pe_eos, busy, err;
  logic [1:0]        dbg_state;

  fv_bank_cntl_gen dut (
    .clk(clk), .reset(reset), .stream_en(stream_en), .cur_replay_iter(cur_replay_iter),
    .fv_num(fv_num), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_node_id(req_node_id), .req_pe_tag(req_pe_tag), .req_data(req_data),
    .req_wr_eos(req_wr_eos), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sm_valid(sm_valid), .sm_sos(sm_sos), .sm_eos(sm_eos), .sm_addr(sm_addr),
    .sm_data(sm_data), .pe_valid(pe_valid), .pe_sos(pe_sos), .pe_eos(pe_eos),
    .pe_tag(pe_tag), .pe_data(pe_data), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM macro, preloaded from the reference memory
  logic [LINE_W-1:0] mem     [DEPTH];
  logic [LINE_W-1:0] ref_mem [DEPTH];
  logic              loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      foreach (mem[i]) mem[i] <= ref_mem[i];
      loaded <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_wdata;
      else           sram_rdata     <= mem[sram_addr];
    end
  end

  // Scoreboard
  logic [SMW-1:0] sm_exp_q[$];
  logic [PEW-1:0] pe_exp_q[$];
  logic [WRW-1:0] wr_exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int sm_cnt   = 0;
  bit m_first_done;
  int m_last;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [255:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h", name, act);
  endtask

  logic [SMW-1:0] e_sm;
  logic [PEW-1:0] e_pe;
  logic [WRW-1:0] e_wr;

  // Monitor: samples on the falling edge
  always @(negedge clk) begin
    if (sm_valid) begin
      sm_cnt++;
      if (sm_exp_q.size() == 0) fail_now("sm_unexpected_beat", sm_addr);
      else begin
        e_sm = sm_exp_q.pop_front();
        chk("sm_beat", {sm_sos, sm_eos, sm_addr, sm_data}, e_sm);
      end
    end
    if (pe_valid) begin
      if (pe_exp_q.size() == 0) fail_now("pe_unexpected_beat", pe_tag);
      else begin
        e_pe = pe_exp_q.pop_front();
        chk("pe_beat", {pe_sos, pe_eos, pe_tag, pe_data}, e_pe);
      end
    end
    if (!sram_cen && !sram_wen) begin
      if (wr_exp_q.size() == 0) fail_now("sram_unexpected_write", sram_addr);
      else begin
        e_wr = wr_exp_q.pop_front();
        chk("sram_write", {sram_addr, sram_wdata}, e_wr);
      end
    end
  end

  // Reference model helpers
  function automatic int nlines_of(input int fv);
    int n;
    n = (fv + EPL - 1) / EPL;
    if (n < 1)   n = 1;
    if (n > LPN) n = LPN;
    return n;
  endfunction

  task automatic push_stream(input int iter, input int fv);
    int nl;
    logic [AW-1:0] a;
    nl = nlines_of(fv);
    for (int n = 0; n < NPI; n++)
      for (int l = 0; l < nl; l++) begin
        a = AW'(iter * NPI * LPN + n * LPN + l);
        sm_exp_q.push_back({(n == 0 && l == 0), (n == NPI - 1 && l == nl - 1), a, ref_mem[a]});
      end
  endtask

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) fail_now("req_ready_timeout", k);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int  k;
    bit  done;
    k    = 0;
    done = 0;
    while (!done && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
      done = !busy && sm_exp_q.size() == 0 && pe_exp_q.size() == 0 && wr_exp_q.size() == 0;
    end
    if (!done) fail_now({name, "_timeout"}, k);
  endtask

  task automatic start_stream(input int iter, input int fv);
    fv_num          = FVW'(fv);
    cur_replay_iter = ITW'(iter);
    if (!m_first_done || iter != m_last) begin
      push_stream(iter, fv);
      m_first_done = 1;
      m_last       = iter;
    end
    stream_en = 1'b1;
    cyc(1);
    wait_idle("stream");
    cyc(3);
  endtask

  task automatic write_job(input int node, input int nbeats, input bit with_eos, input bit gaps);
    logic [LINE_W-1:0] d;
    logic [AW-1:0]     a;
    for (int k = 0; k < nbeats; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      a = AW'(node * LPN + k);
      req_valid   = 1'b1;
      req_wr      = 1'b1;
      req_node_id = NID_W'(node);
      req_data    = d;
      req_wr_eos  = with_eos && (k == nbeats - 1);
      if (k < LPN) begin
        wr_exp_q.push_back({a, d});
        ref_mem[a] = d;
      end
      handshake();
      if (gaps && $urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        cyc($urandom_range(1, 3));
      end
    end
    req_valid  = 1'b0;
    req_wr_eos = 1'b0;
  endtask

  task automatic read_job(input int node, input int tag, input int fv);
    int nl;
    logic [AW-1:0] a;
    logic [TW-1:0] t;
    nl = nlines_of(fv);
    t  = TW'(tag);
    for (int l = 0; l < nl; l++) begin
      a = AW'(node * LPN + l);
      pe_exp_q.push_back({(l == 0), (l == nl - 1), t, ref_mem[a]});
    end
    fv_num      = FVW'(fv);
    req_valid   = 1'b1;
    req_wr      = 1'b0;
    req_node_id = NID_W'(node);
    req_pe_tag  = t;
    handshake();
    req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  // Main sequence
  initial begin
    int base, k, nl;
    reset           = 1'b1;
    stream_en       = 1'b1;
    cur_replay_iter = '0;
    fv_num          = FVW'(64);
    req_valid       = 1'b0;
    req_wr          = 1'b0;
    req_node_id     = '0;
    req_pe_tag      = '0;
    req_data        = '0;
    req_wr_eos      = 1'b0;
    m_first_done    = 0;
    m_last          = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    cyc(3);

    chk("rst_sram_cen", sram_cen, 1);
    chk("rst_sram_wen", sram_wen, 1);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sm_valid", {sm_valid, sm_sos, sm_eos}, 0);
    chk("rst_pe_valid", {pe_valid, pe_sos, pe_eos}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_state", dbg_state, ST_IDLE);

    // Full-width stream of iteration 0
    push_stream(0, 64);
    m_first_done = 1;
    m_last       = 0;
    reset        = 1'b0;
    wait_idle("stream0");
    chk("stream0_busy_after", busy, 0);

    // Same iteration held: no restream, requests blocked
    cyc(20);
    chk("hold_no_restream_q", sm_exp_q.size(), 0);
    chk("hold_req_ready", req_ready, 0);
    chk("hold_busy", busy, 0);

    start_stream(3, 20);

    // Write node 5, three beats
    stream_en = 1'b0;
    cyc(1);
    write_job(5, 3, 1'b1, 1'b0);
    wait_idle("wr5");
    chk("wr5_state", dbg_state, ST_IDLE);
    chk("wr5_err", err, 0);

    // Read node 5 back with tag 2, 17 features -> 3 lines
    read_job(5, 2, 17);
    nl = nlines_of(17);
    for (int i = 0; i < nl - 1; i++) begin
      @(negedge clk);
      chk("rd_req_ready_low", req_ready, 0);
      chk("rd_busy", busy, 1);
    end
    wait_idle("rd5");

    // Overflowing write: nine beats without eos
    write_job(1, 9, 1'b0, 1'b0);
    wait_idle("wr_ovf");
    chk("ovf_err", err, 1);
    chk("ovf_state", dbg_state, ST_IDLE);
    read_job(1, 1, 64);
    wait_idle("rd_ovf");

    // Randomised mix of reads, writes and streams
    for (int op = 0; op < 40; op++) begin
      case ($urandom_range(0, 4))
        0, 1: read_job($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 100));
        2, 3: begin
          wait_idle("rand_pre_wr");
          write_job($urandom_range(0, 63), $urandom_range(1, LPN), 1'b1, 1'b1);
        end
        default: begin
          wait_idle("rand_pre_stream");
          start_stream($urandom_range(1, 7), $urandom_range(0, 100));
          stream_en = 1'b0;
          cyc(1);
        end
      endcase
    end
    wait_idle("rand_end");
    chk("rand_err_sticky", err, 1);

    // Reset in the middle of a stream of iteration 0
    fv_num          = FVW'(64);
    cur_replay_iter = '0;
    push_stream(0, 64);
    stream_en = 1'b1;
    base      = sm_cnt;
    k         = 0;
    while (sm_cnt - base < 10 && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (k >= 500) fail_now("mid_stream_wait_timeout", k);
    #1 reset = 1'b1;
    #1;
    chk("midrst_sm_valid", {sm_valid, sm_sos, sm_eos}, 0);
    chk("midrst_sm_data", sm_data, 0);
    chk("midrst_sram_cen", sram_cen, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    sm_exp_q.delete();
    m_first_done = 0;
    cyc(3);
    push_stream(0, 64);
    m_first_done = 1;
    m_last       = 0;
    reset        = 1'b0;
    wait_idle("restream");
    chk("restream_busy", busy, 0);

    chk("final_sm_q_empty", sm_exp_q.size(), 0);
    chk("final_pe_q_empty", pe_exp_q.size(), 0);
    chk("final_wr_q_empty", wr_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
